// File: rtl/better_neighbor_select_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : better_neighbor_select_if
// Description : Shared node-memory port used by the better-neighbour selector.
//               master = selector side, slave = memory side.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface better_neighbor_select_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic [WORD_WIDTH-1:0] data_in;

  modport master (output address, output wr_en, output data_out, input data_in);
  modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface
`default_nettype wire

// File: rtl/better_neighbor_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : better_neighbor_select
// Description : Walks the neighbour tables in node memory, keeps alive
//               in-cluster neighbours, tracks the lowest HCM-weighted cost
//               hop and the first known-sink neighbour, and writes the
//               better-neighbour list and its count back to memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module better_neighbor_select #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 64,
  parameter int MAX_BETTER    = 16,
  parameter int HCM_LENGTH    = 11,
  parameter int BAT_FRAC      = 15,
  parameter int HCM_FRAC      = 13,
  parameter int STRIDE        = 2,
  parameter logic [WORD_WIDTH-1:0] KSC_ADDR   = 16'h688,
  parameter logic [WORD_WIDTH-1:0] NC_ADDR    = 16'h68A,
  parameter logic [WORD_WIDTH-1:0] BCNT_ADDR  = 16'h68C,
  parameter logic [WORD_WIDTH-1:0] SINK_BASE  = 16'h008,
  parameter logic [WORD_WIDTH-1:0] NID_BASE   = 16'h048,
  parameter logic [WORD_WIDTH-1:0] CID_BASE   = 16'h0C8,
  parameter logic [WORD_WIDTH-1:0] BAT_BASE   = 16'h148,
  parameter logic [WORD_WIDTH-1:0] Q_BASE     = 16'h1C8,
  parameter logic [WORD_WIDTH-1:0] HCM_BASE   = 16'h648,
  parameter logic [WORD_WIDTH-1:0] BLIST_BASE = 16'h668
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] battery_threshold,
  input  logic                  strict_mode,
  better_neighbor_select_if.master mem,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] nextsinks,
  output logic [WORD_WIDTH-1:0] better_count,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = 2 * WORD_WIDTH;
  localparam logic [WORD_WIDTH-1:0] NONE      = WORD_WIDTH'(MAX_NEIGHBORS + 1);
  localparam logic [WORD_WIDTH-1:0] NB_MAX    = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] LIST_MAX  = WORD_WIDTH'(MAX_BETTER);
  localparam logic [WORD_WIDTH-1:0] STEP      = WORD_WIDTH'(STRIDE);
  localparam logic [WORD_WIDTH-1:0] ONE       = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] HCM_TOP   = WORD_WIDTH'(HCM_LENGTH - 1);
  localparam logic [PW-1:0]         HCM_LEN_P = PW'(HCM_LENGTH);
  localparam logic [PW-1:0]         BAT_ROUND = PW'((1 << BAT_FRAC) - 1);

  typedef enum logic [3:0] {
    IDLE, RD_KSC, RD_NC, RD_CID, RD_BAT, RD_Q, WR_BETTER, HCM_IDX,
    RD_HCM, COST, RD_NID, RD_SINK, RD_BEST_ID, WR_COUNT, DONE
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_wr;
  logic [WORD_WIDTH-1:0] ksc;
  logic [WORD_WIDTH-1:0] nc;
  logic [WORD_WIDTH-1:0] idx;
  logic [WORD_WIDTH-1:0] j;
  logic [WORD_WIDTH-1:0] bat;
  logic [WORD_WIDTH-1:0] q;
  logic [WORD_WIDTH-1:0] hcm;
  logic [WORD_WIDTH-1:0] nid;

  logic [WORD_WIDTH-1:0] idx_next;
  logic [WORD_WIDTH-1:0] j_next;
  logic [WORD_WIDTH-1:0] nc_clamp;
  logic [WORD_WIDTH-1:0] k_sel;
  logic [WORD_WIDTH-1:0] cost;
  logic [PW-1:0]         k_prod;
  logic [PW-1:0]         k_ceil;
  logic [PW-1:0]         c_prod;
  logic [PW-1:0]         c_shift;
  logic                  better;
  state_t                adv_state;
  logic [WORD_WIDTH-1:0] adv_addr;
  logic                  adv_wr;

  function automatic logic [WORD_WIDTH-1:0] entry(input logic [WORD_WIDTH-1:0] base,
                                                  input logic [WORD_WIDTH-1:0] n);
    return base + n * STEP;
  endfunction

  // A write already on the bus is dropped the moment abort arrives
  assign mem.address  = mem_addr;
  assign mem.data_out = mem_wdata;
  assign mem.wr_en    = mem_wr & ~(abort & busy);

  // Datapath: HCM index, weighted cost, better test and where to go after neighbour idx
  always_comb begin
    idx_next = idx + ONE;
    j_next   = j + ONE;
    nc_clamp = (mem.data_in > NB_MAX) ? NB_MAX : mem.data_in;
    k_prod   = PW'(bat) * HCM_LEN_P;
    k_ceil   = (k_prod + BAT_ROUND) >> BAT_FRAC;
    k_sel    = (k_ceil >= PW'(HCM_LENGTH)) ? HCM_TOP : k_ceil[WORD_WIDTH-1:0];
    c_prod   = PW'(q) * PW'(hcm);
    c_shift  = c_prod >> HCM_FRAC;
    cost     = (|c_shift[PW-1:WORD_WIDTH]) ? {WORD_WIDTH{1'b1}} : c_shift[WORD_WIDTH-1:0];
    better   = strict_mode ? (mem.data_in < mybest) : (mem.data_in <= mybest);
    adv_state = RD_CID;
    adv_addr  = entry(CID_BASE, idx_next);
    adv_wr    = 1'b0;
    if (idx_next >= nc) begin
      if (besthop == NONE) begin
        // nobody qualified: there is no best ID to fetch
        adv_state = WR_COUNT;
        adv_addr  = BCNT_ADDR;
        adv_wr    = 1'b1;
      end else begin
        adv_state = RD_BEST_ID;
        adv_addr  = entry(NID_BASE, besthop);
      end
    end
  end

  // Control FSM; each read state consumes the address set by the previous state
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state          <= IDLE;
      mem_addr       <= KSC_ADDR;
      mem_wdata      <= '0;
      mem_wr         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      better_count   <= '0;
      besthop        <= NONE;
      nextsinks      <= NONE;
      bestneighborID <= NONE;
      bestvalue      <= '1;
      ksc            <= '0;
      nc             <= '0;
      idx            <= '0;
      j              <= '0;
      bat            <= '0;
      q              <= '0;
      hcm            <= '0;
      nid            <= '0;
    end else if (abort && busy) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            better_count   <= '0;
            besthop        <= NONE;
            nextsinks      <= NONE;
            bestneighborID <= NONE;
            bestvalue      <= '1;
            busy           <= 1'b1;
            mem_addr       <= KSC_ADDR;
            state          <= RD_KSC;
          end
        end
        RD_KSC: begin
          ksc      <= mem.data_in;
          mem_addr <= NC_ADDR;
          state    <= RD_NC;
        end
        RD_NC: begin
          nc  <= nc_clamp;
          idx <= '0;
          if (nc_clamp == '0) begin
            mem_addr  <= BCNT_ADDR;
            mem_wdata <= better_count;
            mem_wr    <= 1'b1;
            state     <= WR_COUNT;
          end else begin
            mem_addr <= CID_BASE;
            state    <= RD_CID;
          end
        end
        RD_CID: begin
          if (mem.data_in != MY_CLUSTER_ID) begin
            idx       <= idx_next;
            mem_addr  <= adv_addr;
            mem_wdata <= better_count;
            mem_wr    <= adv_wr;
            state     <= adv_state;
          end else begin
            mem_addr <= entry(BAT_BASE, idx);
            state    <= RD_BAT;
          end
        end
        RD_BAT: begin
          bat <= mem.data_in;
          if (mem.data_in < battery_threshold) begin
            idx       <= idx_next;
            mem_addr  <= adv_addr;
            mem_wdata <= better_count;
            mem_wr    <= adv_wr;
            state     <= adv_state;
          end else begin
            mem_addr <= entry(Q_BASE, idx);
            state    <= RD_Q;
          end
        end
        RD_Q: begin
          q     <= mem.data_in;
          state <= HCM_IDX;
          if (better) begin
            better_count <= better_count + ONE;
            // past list capacity the count keeps going but nothing is stored
            if (better_count < LIST_MAX) begin
              mem_addr  <= entry(BLIST_BASE, better_count);
              mem_wdata <= idx;
              mem_wr    <= 1'b1;
              state     <= WR_BETTER;
            end
          end
        end
        WR_BETTER: begin
          mem_wr <= 1'b0;
          state  <= HCM_IDX;
        end
        HCM_IDX: begin
          mem_addr <= entry(HCM_BASE, k_sel);
          state    <= RD_HCM;
        end
        RD_HCM: begin
          hcm   <= mem.data_in;
          state <= COST;
        end
        COST: begin
          // strict less-than keeps the lower index on ties
          if (cost < bestvalue) begin
            bestvalue <= cost;
            besthop   <= idx;
          end
          mem_addr <= entry(NID_BASE, idx);
          state    <= RD_NID;
        end
        RD_NID: begin
          nid <= mem.data_in;
          if (ksc == '0) begin
            idx       <= idx_next;
            mem_addr  <= adv_addr;
            mem_wdata <= better_count;
            mem_wr    <= adv_wr;
            state     <= adv_state;
          end else begin
            j        <= '0;
            mem_addr <= SINK_BASE;
            state    <= RD_SINK;
          end
        end
        RD_SINK: begin
          if (mem.data_in == nid || j_next >= ksc) begin
            if (mem.data_in == nid && nextsinks == NONE) begin
              nextsinks <= idx;
            end
            idx       <= idx_next;
            mem_addr  <= adv_addr;
            mem_wdata <= better_count;
            mem_wr    <= adv_wr;
            state     <= adv_state;
          end else begin
            j        <= j_next;
            mem_addr <= entry(SINK_BASE, j_next);
          end
        end
        RD_BEST_ID: begin
          bestneighborID <= mem.data_in;
          mem_addr       <= BCNT_ADDR;
          mem_wdata      <= better_count;
          mem_wr         <= 1'b1;
          state          <= WR_COUNT;
        end
        WR_COUNT: begin
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_better_neighbor_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_better_neighbor_select
// Description : Self-checking bench: directed scenarios plus random tables,
//               each pass compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_better_neighbor_select;

  localparam int KSC   = 16'h688;
  localparam int NCA   = 16'h68A;
  localparam int BCNT  = 16'h68C;
  localparam int SINKB = 16'h008;
  localparam int NIDB  = 16'h048;
  localparam int CIDB  = 16'h0C8;
  localparam int BATB  = 16'h148;
  localparam int QB    = 16'h1C8;
  localparam int HB    = 16'h648;
  localparam int BL    = 16'h668;
  localparam int NONE  = 65;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic        abort;
  logic        strict_mode;
  logic [15:0] my_cluster;
  logic [15:0] mybest;
  logic [15:0] thr;
  logic [15:0] besthop;
  logic [15:0] bestneighborID;
  logic [15:0] nextsinks;
  logic [15:0] better_count;
  logic [15:0] bestvalue;
  logic        busy;
  logic        done;

  better_neighbor_select_if #(.WORD_WIDTH(16)) bus ();

  better_neighbor_select dut (
    .clock             (clock),
    .nrst              (nrst),
    .start             (start),
    .abort             (abort),
    .MY_CLUSTER_ID     (my_cluster),
    .mybest            (mybest),
    .battery_threshold (thr),
    .strict_mode       (strict_mode),
    .mem               (bus),
    .besthop           (besthop),
    .bestneighborID    (bestneighborID),
    .nextsinks         (nextsinks),
    .better_count      (better_count),
    .bestvalue         (bestvalue),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  // node memory: combinational read of the registered address
  logic [15:0] mem [0:2047];
  assign bus.data_in = mem[bus.address[11:1]];

  // write log, sampled like a real memory at the clock edge
  int wq_addr[$];
  int wq_data[$];
  always @(posedge clock) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(int'(bus.address));
      wq_data.push_back(int'(bus.data_out));
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int rd(input int a);
    return int'(mem[a[11:1]]);
  endfunction

  task automatic put(input int a, input int v);
    mem[a[11:1]] = 16'(v);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0;
    for (int k = 0; k < 11; k++) put(HB + 2 * k, 8192 + 512 * k);
  endtask

  // expected results of one pass
  int e_bh, e_bv, e_ns, e_bid, e_cnt;
  int ew_addr[$];
  int ew_data[$];

  task automatic model();
    int  nc, ksc, bat, q, hcm, k, nid;
    longint c;
    nc = rd(NCA);
    if (nc > 64) nc = 64;
    ksc = rd(KSC);
    e_bh = NONE; e_bv = 65535; e_ns = NONE; e_bid = NONE; e_cnt = 0;
    ew_addr.delete();
    ew_data.delete();
    for (int i = 0; i < nc; i++) begin
      if (rd(CIDB + 2 * i) != int'(my_cluster)) continue;
      bat = rd(BATB + 2 * i);
      if (bat < int'(thr)) continue;
      q = rd(QB + 2 * i);
      if (strict_mode ? (q < int'(mybest)) : (q <= int'(mybest))) begin
        if (e_cnt < 16) begin
          ew_addr.push_back(BL + 2 * e_cnt);
          ew_data.push_back(i);
        end
        e_cnt++;
      end
      k = (11 * bat + 32767) / 32768;
      if (k > 10) k = 10;
      hcm = rd(HB + 2 * k);
      c = (longint'(q) * longint'(hcm)) / 8192;
      if (c > 65535) c = 65535;
      if (c < longint'(e_bv)) begin
        e_bv = int'(c);
        e_bh = i;
      end
      nid = rd(NIDB + 2 * i);
      for (int s = 0; s < ksc; s++) begin
        if (rd(SINKB + 2 * s) == nid) begin
          if (e_ns == NONE) e_ns = i;
          break;
        end
      end
    end
    if (e_bh != NONE) e_bid = rd(NIDB + 2 * e_bh);
    ew_addr.push_back(BCNT);
    ew_data.push_back(e_cnt);
  endtask

  task automatic check_reset(input string t);
    check($sformatf("%s_busy", t), busy, 0);
    check($sformatf("%s_done", t), done, 0);
    check($sformatf("%s_wr_en", t), bus.wr_en, 0);
    check($sformatf("%s_data_out", t), bus.data_out, 0);
    check($sformatf("%s_count", t), better_count, 0);
    check($sformatf("%s_besthop", t), besthop, NONE);
    check($sformatf("%s_nextsinks", t), nextsinks, NONE);
    check($sformatf("%s_bestid", t), bestneighborID, NONE);
    check($sformatf("%s_bestvalue", t), bestvalue, 16'hFFFF);
    check($sformatf("%s_address", t), bus.address, KSC);
  endtask

  // one full pass; extra_start >= 1 re-pulses start that many cycles in
  task automatic run_pass(input string tag, input int extra_start, output int cycles);
    int  base, dones, n;
    bit  seen;
    model();
    base = wq_addr.size();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check($sformatf("%s_busy_after_start", tag), busy, 1);
    cycles = 1;
    seen = 1'b0;
    for (int c = 1; c < 6000 && !seen; c++) begin
      start = (c == extra_start) ? 1'b1 : 1'b0;
      @(negedge clock);
      cycles++;
      if (done) begin
        seen = 1'b1;
        check($sformatf("%s_busy_at_done", tag), busy, 0);
      end
    end
    start = 1'b0;
    check($sformatf("%s_done_seen", tag), seen, 1);
    dones = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) dones++;
    end
    check($sformatf("%s_single_done", tag), dones, 0);
    check($sformatf("%s_besthop", tag), besthop, e_bh);
    check($sformatf("%s_bestvalue", tag), bestvalue, e_bv);
    check($sformatf("%s_nextsinks", tag), nextsinks, e_ns);
    check($sformatf("%s_bestid", tag), bestneighborID, e_bid);
    check($sformatf("%s_count", tag), better_count, e_cnt);
    n = wq_addr.size() - base;
    check($sformatf("%s_nwrites", tag), n, ew_addr.size());
    for (int k = 0; k < n && k < ew_addr.size(); k++) begin
      check($sformatf("%s_wr%0d_addr", tag, k), wq_addr[base + k], ew_addr[k]);
      check($sformatf("%s_wr%0d_data", tag, k), wq_data[base + k], ew_data[k]);
    end
  endtask

  task automatic setup_single();
    clear_mem();
    my_cluster = 16'd5; thr = 16'd328; mybest = 16'd0; strict_mode = 1'b1;
    put(KSC, 0); put(NCA, 3);
    put(CIDB + 0, 2);     put(CIDB + 2, 5);   put(CIDB + 4, 5);
    put(BATB + 0, 29491); put(BATB + 2, 164); put(BATB + 4, 16384);
    put(QB + 0, 128);     put(QB + 2, 128);   put(QB + 4, 128);
    put(NIDB + 0, 10);    put(NIDB + 2, 11);  put(NIDB + 4, 12);
    put(HB + 12, 8192);
  endtask

  task automatic setup_capacity();
    clear_mem();
    my_cluster = 16'd5; thr = 16'd328; mybest = 16'd1000; strict_mode = 1'b1;
    put(KSC, 0); put(NCA, 20);
    for (int i = 0; i < 20; i++) begin
      put(CIDB + 2 * i, 5);
      put(BATB + 2 * i, 16384);
      put(QB + 2 * i, 10 + i);
      put(NIDB + 2 * i, 100 + i);
    end
  endtask

  initial begin
    int cyc, cyc2, base, dn;
    bit seen;
    nrst = 1'b0; start = 1'b0; abort = 1'b0; strict_mode = 1'b1;
    my_cluster = 16'd5; mybest = 16'd0; thr = 16'd0;
    clear_mem();
    repeat (3) @(negedge clock);
    check_reset("reset");
    nrst = 1'b1;
    @(negedge clock);

    // only neighbour 2 survives the cluster and battery filters
    setup_single();
    run_pass("single", -1, cyc);
    check("single_bh_const", besthop, 2);
    check("single_bv_const", bestvalue, 128);

    // inclusive vs strict compare at q == mybest
    setup_single();
    mybest = 16'd128; strict_mode = 1'b0;
    run_pass("incl", -1, cyc);
    check("incl_count_const", better_count, 1);
    strict_mode = 1'b1;
    run_pass("strict", -1, cyc);
    check("strict_count_const", better_count, 0);

    // cost tie (1 and 2) plus a saturating neighbour 0
    clear_mem();
    my_cluster = 16'd5; thr = 16'd328; mybest = 16'd0; strict_mode = 1'b1;
    put(KSC, 0); put(NCA, 3); put(HB + 12, 8192); put(HB + 20, 65454);
    for (int i = 0; i < 3; i++) put(CIDB + 2 * i, 5);
    put(BATB + 0, 32767); put(BATB + 2, 16384); put(BATB + 4, 16384);
    put(QB + 0, 16'hFFFF); put(QB + 2, 200);  put(QB + 4, 200);
    run_pass("tie", -1, cyc);
    check("tie_bh_const", besthop, 1);
    put(NCA, 1);
    run_pass("sat", -1, cyc);
    check("sat_bv_const", bestvalue, 16'hFFFF);

    // sink priority and empty sink list
    clear_mem();
    my_cluster = 16'd5; thr = 16'd328; mybest = 16'd0; strict_mode = 1'b1;
    put(KSC, 3); put(NCA, 4);
    put(SINKB + 0, 21); put(SINKB + 2, 20); put(SINKB + 4, 30);
    for (int i = 0; i < 4; i++) begin
      put(CIDB + 2 * i, 5); put(BATB + 2 * i, 20000); put(QB + 2 * i, 300 - 10 * i);
    end
    put(NIDB + 0, 7); put(NIDB + 2, 20); put(NIDB + 4, 8); put(NIDB + 6, 21);
    run_pass("sink", -1, cyc);
    check("sink_ns_const", nextsinks, 1);
    put(KSC, 0);
    run_pass("nosink", -1, cyc);

    // list capacity and empty table
    setup_capacity();
    run_pass("cap", -1, cyc);
    check("cap_count_const", better_count, 20);
    clear_mem();
    put(NCA, 0);
    run_pass("nc0", -1, cyc);

    // start while busy changes neither results nor timing
    setup_single();
    run_pass("ref", -1, cyc);
    run_pass("restart", 15, cyc2);
    check("restart_cycles", cyc2, cyc);

    // early abort: idle next cycle, no done, no write
    setup_capacity();
    base = wq_addr.size();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check("abort_busy", busy, 0);
    dn = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_no_write", wq_addr.size() - base, 0);

    // abort during a write cycle suppresses the strobe
    setup_capacity();
    base = wq_addr.size();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clock);
      if (bus.wr_en) seen = 1'b1;
    end
    check("abortwr_seen", seen, 1);
    abort = 1'b1;
    #1;
    check("abortwr_gate", bus.wr_en, 0);
    @(negedge clock); abort = 1'b0;
    check("abortwr_busy", busy, 0);
    check("abortwr_hold_count", better_count, 1);
    repeat (5) @(negedge clock);
    check("abortwr_no_write", wq_addr.size() - base, 0);

    // abort with the block idle does nothing
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_count", better_count, 1);

    // synchronous reset mid-pass
    setup_capacity();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (40) @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    check_reset("midreset");
    nrst = 1'b1;

    // random tables
    for (int t = 0; t < 12; t++) begin
      int n, ks, cl;
      clear_mem();
      for (int k = 0; k < 11; k++) put(HB + 2 * k, int'($urandom_range(0, 65535)));
      cl = int'($urandom_range(1, 4));
      my_cluster = 16'(cl);
      thr = 16'($urandom_range(0, 16'h4000));
      mybest = 16'($urandom_range(0, 16'h3000));
      strict_mode = 1'($urandom_range(0, 1));
      n = (t == 0) ? 100 : int'($urandom_range(0, 70));
      ks = int'($urandom_range(0, 6));
      put(NCA, n); put(KSC, ks);
      for (int s = 0; s < 6; s++) put(SINKB + 2 * s, int'($urandom_range(0, 15)));
      for (int i = 0; i < 64; i++) begin
        put(CIDB + 2 * i, ($urandom_range(0, 9) < 7) ? cl : cl + 1);
        put(BATB + 2 * i, int'($urandom_range(0, 65535)));
        put(QB + 2 * i, ($urandom_range(0, 7) == 0) ? 16'hFFFF : int'($urandom_range(0, 16'h3000)));
        put(NIDB + 2 * i, int'($urandom_range(0, 15)));
      end
      run_pass($sformatf("rnd%0d", t), -1, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
